// File: rtl/xtea_port_arbiter.sv
// xtea_port_arbiter: lock-based sharing of the XTEA port window between two port-bus masters
module xtea_port_arbiter #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter bit AUTO_RELEASE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] m0_port_id,
  input  logic [7:0] m0_out_port,
  input  logic       m0_write_strobe,
  input  logic       m0_read_strobe,
  output logic [7:0] m0_in_port,
  input  logic [7:0] m1_port_id,
  input  logic [7:0] m1_out_port,
  input  logic       m1_write_strobe,
  input  logic       m1_read_strobe,
  output logic [7:0] m1_in_port,
  output logic [7:0] x_port_id,
  output logic [7:0] x_out_port,
  output logic       x_write_strobe,
  output logic       x_read_strobe,
  input  logic [7:0] x_in_port,
  output logic [1:0] owner
);
  localparam int TW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [1:0] IDLE = 2'b00, OWN0 = 2'b01, OWN1 = 2'b10;
  logic [1:0] state, pend, pend_n, tof, tof_n, wr, rd, win, core, lock_w, stat_w;
  logic [7:0] pid [2];
  logic [7:0] dat [2];
  logic [7:0] inp [2];
  logic last, o, owned, fwd, acc_o, rc_hit, rel, g_valid, g;
  logic [3:0] rc;
  logic [TW-1:0] tcnt;
  logic [7:0] last_id, last_out;
  assign pid = '{m0_port_id, m1_port_id};
  assign dat = '{m0_out_port, m1_out_port};
  assign wr = {m1_write_strobe, m0_write_strobe};
  assign rd = {m1_read_strobe, m0_read_strobe};
  assign owner = state;
  assign o = state[1];
  assign owned = |state;
  assign fwd = owned && core[o];
  assign acc_o = owned && win[o] && (wr[o] || rd[o]);
  assign rc_hit = owned && rd[o] && pid[o] == 8'h35;
  assign g_valid = state == IDLE && |pend;
  assign g = &pend ? ~last : pend[1];
  assign x_port_id = fwd ? pid[o] : last_id;
  assign x_out_port = fwd ? dat[o] : last_out;
  assign x_write_strobe = fwd && wr[o];
  assign x_read_strobe = fwd && rd[o];
  assign m0_in_port = inp[0];
  assign m1_in_port = inp[1];
  // per-master address decode and read-data mux; core reads only reach the lock owner
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      win[i] = pid[i][7:4] == 4'h3;
      core[i] = win[i] && pid[i][3:1] != 3'b111;
      lock_w[i] = wr[i] && pid[i] == 8'h3E;
      stat_w[i] = wr[i] && pid[i] == 8'h3F;
      inp[i] = core[i] ? (state[i] ? x_in_port : 8'h00) :
               pid[i] == 8'h3E ? {6'b0, state[i], owned} :
               pid[i] == 8'h3F ? {4'b0, tof, state} : 8'h00;
    end
  end
  // release sources; the idle timer fires only on a cycle with no owner window access
  always_comb begin
    rel = owned && ((lock_w[o] && !dat[o][0]) ||
                    (AUTO_RELEASE && rc_hit && rc == 4'd7) ||
                    (TIMEOUT_CYCLES != 0 && !acc_o &&
                     {{(32 - TW){1'b0}}, tcnt} == 32'(TIMEOUT_CYCLES - 1)));
  end
  // next pending requests and sticky timeout flags; a LOCK write beats the grant clear
  always_comb begin
    pend_n = pend;
    tof_n = tof;
    if (g_valid) pend_n[g] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (lock_w[i] && !state[i]) pend_n[i] = dat[i][0];
      if (stat_w[i] && dat[i][0]) tof_n[i] = 1'b0;
    end
    if (rel && !acc_o && !(lock_w[o] && !dat[o][0]) && !(AUTO_RELEASE && rc_hit && rc == 4'd7)) tof_n[o] = 1'b1;
  end
  // ownership FSM, counters and held core address/data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pend <= 2'b00;
      tof <= 2'b00;
      last <= 1'b1;
      rc <= 4'd0;
      tcnt <= '0;
      last_id <= 8'h00;
      last_out <= 8'h00;
    end else begin
      state <= g_valid ? (g ? OWN1 : OWN0) : rel ? IDLE : state;
      pend <= pend_n;
      tof <= tof_n;
      last <= g_valid ? g : last;
      rc <= g_valid ? 4'd0 : (rc_hit && rc != 4'd8) ? rc + 4'd1 : rc;
      tcnt <= (g_valid || acc_o) ? '0 : owned ? tcnt + 1'b1 : tcnt;
      if (fwd) begin
        last_id <= pid[o];
        last_out <= dat[o];
      end
    end
  end
endmodule

// File: tb/tb_xtea_port_arbiter.sv
// tb_xtea_port_arbiter: random and directed port traffic checked against a behavioural lock model
module tb_xtea_port_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic [7:0] mp [2];
  logic [7:0] md [2];
  logic mw [2];
  logic mr [2];
  logic [7:0] mi [2];
  logic [7:0] x_port_id, x_out_port, xin;
  logic x_write_strobe, x_read_strobe;
  logic [1:0] owner;
  int n_vec = 0, n_err = 0;
  int own, last, rc, idle_n;
  bit pend [2];
  bit tof [2];
  logic [7:0] xid;

  xtea_port_arbiter #(.TIMEOUT_CYCLES(16), .AUTO_RELEASE(1'b1)) dut (
    .clk(clk), .rst(rst),
    .m0_port_id(mp[0]), .m0_out_port(md[0]), .m0_write_strobe(mw[0]), .m0_read_strobe(mr[0]), .m0_in_port(mi[0]),
    .m1_port_id(mp[1]), .m1_out_port(md[1]), .m1_write_strobe(mw[1]), .m1_read_strobe(mr[1]), .m1_in_port(mi[1]),
    .x_port_id(x_port_id), .x_out_port(x_out_port), .x_write_strobe(x_write_strobe),
    .x_read_strobe(x_read_strobe), .x_in_port(xin), .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %02h expected %02h", tag, $time, got, exp);
    end
  endtask

  task automatic mreset();
    own = 0; last = 1; rc = 0; idle_n = 0; xid = 8'h00;
    pend = '{0, 0};
    tof = '{0, 0};
  endtask

  task automatic clr();
    for (int m = 0; m < 2; m++) begin
      mp[m] = 8'h00; md[m] = 8'h00; mw[m] = 1'b0; mr[m] = 1'b0;
    end
  endtask

  task automatic drv(input int m, input logic [7:0] p, input logic [7:0] d, input bit w, input bit r);
    mp[m] = p; md[m] = d; mw[m] = w; mr[m] = r;
  endtask

  function automatic bit is_core(input logic [7:0] p);
    return p >= 8'h30 && p <= 8'h3D;
  endfunction

  function automatic logic [7:0] exp_in(input int m);
    if (is_core(mp[m])) return own == m + 1 ? xin : 8'h00;
    if (mp[m] == 8'h3E) return {6'b0, own == m + 1, own != 0};
    if (mp[m] == 8'h3F) return {4'b0, tof[1], tof[0], 2'(own)};
    return 8'h00;
  endfunction

  task automatic check_outputs();
    int o;
    bit f;
    o = own > 0 ? own - 1 : 0;
    f = own != 0 && is_core(mp[o]);
    chk("owner", 8'(owner), 8'(own));
    chk("x_write_strobe", 8'(x_write_strobe), 8'(f && mw[o]));
    chk("x_read_strobe", 8'(x_read_strobe), 8'(f && mr[o]));
    chk("x_port_id", x_port_id, f ? mp[o] : xid);
    if (f) chk("x_out_port", x_out_port, md[o]);
    chk("m0_in_port", mi[0], exp_in(0));
    chk("m1_in_port", mi[1], exp_in(1));
  endtask

  task automatic update();
    int g, o;
    bit rel, acc;
    g = -1; rel = 0; o = own - 1;
    for (int m = 0; m < 2; m++)
      if (mw[m] && mp[m] == 8'h3F && md[m][0]) tof[m] = 0;
    if (own == 0) begin
      if (pend[0] && pend[1]) g = last == 0 ? 1 : 0;
      else if (pend[0]) g = 0;
      else if (pend[1]) g = 1;
    end else begin
      acc = (mw[o] || mr[o]) && mp[o][7:4] == 4'h3;
      if (is_core(mp[o])) xid = mp[o];
      if (mw[o] && mp[o] == 8'h3E && !md[o][0]) rel = 1;
      if (mr[o] && mp[o] == 8'h35) begin
        if (rc < 8) rc++;
        if (rc == 8) rel = 1;
      end
      idle_n = acc ? 0 : idle_n + 1;
      if (idle_n == 16) begin
        rel = 1;
        tof[o] = 1;
      end
    end
    if (g >= 0) pend[g] = 0;
    for (int m = 0; m < 2; m++)
      if (mw[m] && mp[m] == 8'h3E && own != m + 1) pend[m] = md[m][0];
    if (g >= 0) begin
      own = g + 1; last = g; rc = 0; idle_n = 0;
    end else if (rel) own = 0;
  endtask

  task automatic cyc();
    xin = 8'($urandom);
    #1;
    check_outputs();
    @(posedge clk);
    update();
    @(negedge clk);
    clr();
  endtask

  function automatic logic [7:0] rnd_port();
    case ($urandom_range(0, 7))
      0: return 8'h30;
      1: return 8'h31;
      2: return 8'h34;
      3, 4: return 8'h35;
      5: return 8'h3E;
      6: return 8'h3F;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic rnd_cycles(input int n, input int wr_odds);
    for (int k = 0; k < n; k++) begin
      for (int m = 0; m < 2; m++) begin
        mp[m] = rnd_port();
        md[m] = 8'($urandom);
        if (mp[m] == 8'h3E && $urandom_range(0, 3) != 0) md[m][0] = 1'b1;
        mw[m] = $urandom_range(0, wr_odds) == 0;
        mr[m] = $urandom_range(0, 2) == 0;
      end
      cyc();
    end
  endtask

  initial begin
    rst = 1'b1;
    clr();
    xin = 8'h5A;
    mreset();
    @(negedge clk);
    drv(0, 8'h3E, 8'h00, 0, 1);
    #1;
    chk("rst_owner", 8'(owner), 8'h00);
    chk("rst_x_write", 8'(x_write_strobe), 8'h00);
    chk("rst_x_port_id", x_port_id, 8'h00);
    chk("rst_m0_in", mi[0], 8'h00);
    @(negedge clk);
    rst = 1'b0;
    clr();
    drv(0, 8'h3E, 8'h01, 1, 0); cyc();
    cyc();
    drv(0, 8'h3E, 8'h00, 0, 1); drv(1, 8'h3E, 8'h00, 0, 1); cyc();
    drv(1, 8'h30, 8'hAA, 1, 0); cyc();
    drv(1, 8'h34, 8'h00, 0, 1); cyc();
    drv(0, 8'h30, 8'h55, 1, 0); cyc();
    drv(1, 8'h3E, 8'h01, 1, 0); cyc();
    for (int k = 0; k < 8; k++) begin
      drv(0, 8'h35, 8'h00, 0, 1); cyc();
    end
    repeat (3) cyc();
    drv(1, 8'h3E, 8'h00, 1, 0); cyc();
    repeat (20) cyc();
    drv(1, 8'h3F, 8'h00, 0, 1); cyc();
    drv(1, 8'h3F, 8'h01, 1, 0); cyc();
    drv(1, 8'h3F, 8'h00, 0, 1); cyc();
    drv(0, 8'h3E, 8'h01, 1, 0); drv(1, 8'h3E, 8'h01, 1, 0); cyc();
    cyc();
    drv(0, 8'h3E, 8'h00, 1, 0); cyc();
    drv(0, 8'h3E, 8'h01, 1, 0); drv(1, 8'h3E, 8'h01, 1, 0); cyc();
    repeat (2) cyc();
    rnd_cycles(800, 3);
    rnd_cycles(800, 12);
    drv(0, 8'h3E, 8'h00, 1, 0); drv(1, 8'h3E, 8'h00, 1, 0); cyc();
    repeat (20) cyc();
    drv(0, 8'h3E, 8'h01, 1, 0); cyc();
    cyc();
    drv(0, 8'h31, 8'hC3, 1, 0);
    xin = 8'h77;
    #1;
    check_outputs();
    rst = 1'b1;
    #1;
    chk("midrst_x_write", 8'(x_write_strobe), 8'h00);
    chk("midrst_owner", 8'(owner), 8'h00);
    chk("midrst_x_port_id", x_port_id, 8'h00);
    mreset();
    @(negedge clk);
    rst = 1'b0;
    cyc();
    drv(0, 8'h30, 8'h12, 1, 1); cyc();
    rnd_cycles(600, 4);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/xtea_port_arbiter.md
Name: xtea_port_arbiter

Overview:
- Shares one XTEA port-bus peripheral window (port_id 0x30–0x3F) between two PicoBlaze-style port-bus masters (m0, m1).
- Each master must acquire a lock before touching the XTEA core. Only the lock owner's accesses reach the core.
- Sits between the two masters' port buses and the XTEA core's port interface; ports outside the window are decoded elsewhere and ignored here.

Parameters:
- TIMEOUT_CYCLES, 4096: owner idle cycles (no window access) before forced release; 0 disables timeout.
- AUTO_RELEASE, 1: 1 = release the lock automatically after the owner's 8th read of port 0x35 in the session.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- m0_port_id  in  8  master 0 port address
- m0_out_port  in  8  master 0 write data
- m0_write_strobe  in  1  master 0 write pulse
- m0_read_strobe  in  1  master 0 read pulse
- m0_in_port  out  8  read data to master 0
- m1_port_id / m1_out_port / m1_write_strobe / m1_read_strobe / m1_in_port: same as m0, for master 1
- x_port_id  out  8  port address to XTEA core
- x_out_port  out  8  write data to XTEA core
- x_write_strobe  out  1  write pulse to XTEA core
- x_read_strobe  out  1  read pulse to XTEA core
- x_in_port  in  8  read data from XTEA core
- owner  out  2  00 none, 01 m0, 10 m1 (debug)

Behaviour:
- Window: port_id[7:4]==4'h3. Arbiter registers: 0x3E (LOCK) and 0x3F (STATUS). Core ports: 0x30–0x3D.
- Reset: state IDLE, owner=00, pending requests cleared, last_owner=m1 (so m0 wins the first tie), timeout flags 0, counters 0. All x_* outputs are 0 and m*_in_port is 0 while rst is high. Reset mid-session drops the lock immediately.
- LOCK write 0x3E, data bit0=1: sets that master's pending request. Ignored if that master is already the owner.
- LOCK write 0x3E, data bit0=0:
  - From the owner: release, state becomes IDLE next cycle.
  - From a non-owner: clears only its own pending request.
- LOCK read: m*_in_port = {6'b0, is_owner, locked}.
- STATUS read 0x3F: {4'b0, to_flag_m1, to_flag_m0, owner[1:0]}.
- STATUS write 0x3F, bit0=1: clears the writer's own timeout flag.
- FSM states:
  - IDLE: if exactly one request is pending, grant it. If both are pending, grant the master that is not last_owner. Grant is registered: ownership becomes visible the cycle after a pending request is seen in IDLE. The granted master's pending bit is cleared.
  - OWN0 / OWN1: return to IDLE on any of these:
    - owner release write;
    - AUTO_RELEASE and result-read count reaches 8;
    - timeout.
  - After any release the FSM spends at least one cycle in IDLE before a new grant. Back-to-back ownership therefore has a minimum 1-cycle gap.
- Forwarding (combinational, zero added latency):
  - In OWNn, master n's accesses to 0x30–0x3D drive x_port_id, x_out_port and the x strobes directly.
  - m{n}_in_port = x_in_port whenever master n's port_id is 0x30–0x3D.
  - When idle, x_port_id holds its last registered value and strobes are 0.
- Non-owner accesses to 0x30–0x3D:
  - Writes are dropped; no x_* strobe is generated.
  - Reads return 0x00 (so a ready poll of 0x34 reads "not ready") and x_read_strobe is not asserted.
- Simultaneous events:
  - Owner release and other master's request in the same cycle: release wins this cycle; grant follows after the IDLE cycle.
  - Both masters writing LOCK=1 in the same cycle: tie broken by last_owner.
- Result counter: 4 bits. Increments on each owner read_strobe with port_id 0x35. Cleared on grant. Saturates at 8.
- Timeout counter:
  - Width $clog2(TIMEOUT_CYCLES+1). Reset to 0 on grant and on every owner window access; increments each cycle in OWNn.
  - Reaching TIMEOUT_CYCLES forces release and sets that owner's to_flag (sticky).
- Port_id outside the window: m*_in_port = 0x00, nothing forwarded.

Test Plan:
- m0 writes 0x3E←01, then reads 0x3E two cycles later → reads 0x03. m1 reads 0x3E → 0x00. owner=01.
- m0 owns; m1 writes 0x30←AA and reads 0x34 → no x_write_strobe/x_read_strobe, m1_in_port=0x00. m0 writes 0x30←55 → x_port_id=0x30, x_out_port=0x55, x_write_strobe same cycle.
- AUTO_RELEASE=1: m0 does 8 read_strobes on 0x35 → owner=00 the cycle after the 8th read. Pending m1 request → owner=10 after one IDLE cycle.
- m0 and m1 write 0x3E←01 in the same cycle after reset → m0 granted. After m0 releases, both request again in the same cycle → m1 granted.
- TIMEOUT_CYCLES=16: m1 acquires, then stays silent → forced release after 16 cycles; m1 reading 0x3F → 0x08. m1 writes 0x3F←01 → next read 0x00.
- Assert rst while m0 owns and mid-write to 0x31 → x_write_strobe=0 and owner=00 immediately. After deassert, m0 must re-request before any forwarding occurs.
